// File: rtl/sdram_req_arb.sv
// Slot-based SDRAM request arbiter: 16-phase slots aligned to clkref, fixed priority ldr > ppu > cpu.
// Define SDRAM_ARB_REFRESH_GUARD_EN to force an idle (refresh) slot after GUARD_SLOTS consecutive busy slots.
module sdram_req_arb #(
  parameter int unsigned GUARD_SLOTS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clkref,
  input  logic        ldr_req,
  input  logic [24:0] ldr_addr,
  input  logic [7:0]  ldr_din,
  output logic        ldr_ack,
  input  logic        ppu_req,
  input  logic [24:0] ppu_addr,
  output logic        ppu_ack,
  output logic [7:0]  ppu_dout,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [24:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic        cpu_ack,
  output logic [7:0]  cpu_dout,
  output logic [24:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_din,
  output logic        mem_oeA,
  output logic        mem_oeB,
  input  logic [7:0]  mem_doutA,
  input  logic [7:0]  mem_doutB
);

  localparam int unsigned PH_W = 4;
  localparam int unsigned AW   = 25;
  localparam int unsigned DW   = 8;
  localparam logic [PH_W-1:0] PH_FIRST = PH_W'(0);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(15);
  localparam logic [PH_W-1:0] PH_ACK   = PH_W'(8);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LDR    = 3'd1,
    S_PPU    = 3'd2,
    S_CPU_RD = 3'd3,
    S_CPU_WR = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [PH_W-1:0] r_ph, w_ph_nxt;
  logic            w_slot_start;
  logic            w_guard_idle;

  logic [AW-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [DW-1:0]   r_mem_din, w_mem_din_nxt;
  logic            r_mem_we, w_mem_we_nxt;
  logic            r_mem_oea, w_mem_oea_nxt;
  logic            r_mem_oeb, w_mem_oeb_nxt;
  logic            r_ldr_ack, w_ldr_ack_nxt;
  logic            r_ppu_ack, w_ppu_ack_nxt;
  logic            r_cpu_ack, w_cpu_ack_nxt;
  logic [DW-1:0]   r_cpu_dout, w_cpu_dout_nxt;
  logic [DW-1:0]   r_ppu_dout, w_ppu_dout_nxt;

  // Phase lock: stall at 15 until clkref high, stall at 0 until clkref low.
  always_comb begin
    w_ph_nxt = r_ph + PH_W'(1);
    if ((r_ph == PH_LAST) && !clkref) w_ph_nxt = r_ph;
    else if ((r_ph == PH_FIRST) && clkref) w_ph_nxt = r_ph;
  end

  assign w_slot_start = (r_ph == PH_LAST) && clkref;

  always_ff @(posedge clk) begin
    if (!reset_n) r_ph <= PH_FIRST;
    else          r_ph <= w_ph_nxt;
  end

`ifdef SDRAM_ARB_REFRESH_GUARD_EN
  localparam int unsigned BUSY_W = $clog2(GUARD_SLOTS + 1);
  localparam logic [BUSY_W-1:0] BUSY_MAX = BUSY_W'(GUARD_SLOTS);

  logic [BUSY_W-1:0] r_busy_cnt;

  assign w_guard_idle = (r_busy_cnt == BUSY_MAX);

  // Consecutive granted slots, saturating; any idle slot clears it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_busy_cnt <= '0;
    end else if (w_slot_start) begin
      if (w_state_nxt == S_IDLE)     r_busy_cnt <= '0;
      else if (r_busy_cnt != BUSY_MAX) r_busy_cnt <= r_busy_cnt + BUSY_W'(1);
    end
  end
`else
  assign w_guard_idle = 1'b0;
`endif

  // State register: the slot owner, changed only at slot start.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state: fixed-priority grant at slot start.
  always_comb begin
    w_state_nxt = r_state;
    if (w_slot_start) begin
      if (w_guard_idle)  w_state_nxt = S_IDLE;
      else if (ldr_req)  w_state_nxt = S_LDR;
      else if (ppu_req)  w_state_nxt = S_PPU;
      else if (cpu_req)  w_state_nxt = cpu_we ? S_CPU_WR : S_CPU_RD;
      else               w_state_nxt = S_IDLE;
    end
  end

  // Output decode: bus payload latched at slot start, ack and read data on the 8->9 edge.
  always_comb begin
    w_mem_addr_nxt = r_mem_addr;
    w_mem_din_nxt  = r_mem_din;
    w_mem_we_nxt   = (w_state_nxt == S_LDR) || (w_state_nxt == S_CPU_WR);
    w_mem_oea_nxt  = (w_state_nxt == S_CPU_RD);
    w_mem_oeb_nxt  = (w_state_nxt == S_PPU);
    w_ldr_ack_nxt  = 1'b0;
    w_ppu_ack_nxt  = 1'b0;
    w_cpu_ack_nxt  = 1'b0;
    w_cpu_dout_nxt = r_cpu_dout;
    w_ppu_dout_nxt = r_ppu_dout;

    if (w_slot_start) begin
      case (w_state_nxt)
        S_LDR: begin
          w_mem_addr_nxt = ldr_addr;
          w_mem_din_nxt  = ldr_din;
        end
        S_PPU: begin
          w_mem_addr_nxt = ppu_addr;
        end
        S_CPU_RD, S_CPU_WR: begin
          w_mem_addr_nxt = cpu_addr;
          w_mem_din_nxt  = cpu_din;
        end
        default: ;
      endcase
    end

    if (r_ph == PH_ACK) begin
      w_ldr_ack_nxt = (r_state == S_LDR);
      w_ppu_ack_nxt = (r_state == S_PPU);
      w_cpu_ack_nxt = (r_state == S_CPU_RD) || (r_state == S_CPU_WR);
      if (r_state == S_CPU_RD) w_cpu_dout_nxt = mem_doutA;
      if (r_state == S_PPU)    w_ppu_dout_nxt = mem_doutB;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_mem_we   <= 1'b0;
      r_mem_oea  <= 1'b0;
      r_mem_oeb  <= 1'b0;
      r_ldr_ack  <= 1'b0;
      r_ppu_ack  <= 1'b0;
      r_cpu_ack  <= 1'b0;
      r_cpu_dout <= '0;
      r_ppu_dout <= '0;
    end else begin
      r_mem_addr <= w_mem_addr_nxt;
      r_mem_din  <= w_mem_din_nxt;
      r_mem_we   <= w_mem_we_nxt;
      r_mem_oea  <= w_mem_oea_nxt;
      r_mem_oeb  <= w_mem_oeb_nxt;
      r_ldr_ack  <= w_ldr_ack_nxt;
      r_ppu_ack  <= w_ppu_ack_nxt;
      r_cpu_ack  <= w_cpu_ack_nxt;
      r_cpu_dout <= w_cpu_dout_nxt;
      r_ppu_dout <= w_ppu_dout_nxt;
    end
  end

  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;
  assign mem_we   = r_mem_we;
  assign mem_oeA  = r_mem_oea;
  assign mem_oeB  = r_mem_oeb;
  assign ldr_ack  = r_ldr_ack;
  assign ppu_ack  = r_ppu_ack;
  assign cpu_ack  = r_cpu_ack;
  assign cpu_dout = r_cpu_dout;
  assign ppu_dout = r_ppu_dout;

endmodule

// File: tb/tb_sdram_req_arb.sv
// Directed bench for sdram_req_arb: clkref is driven from a phase model so each slot is 16 clocks.
module tb_sdram_req_arb;

  logic        clk = 1'b0;
  logic        reset_n, clkref;
  logic        ldr_req, ppu_req, cpu_req, cpu_we;
  logic [24:0] ldr_addr, ppu_addr, cpu_addr;
  logic [7:0]  ldr_din, cpu_din;
  logic        ldr_ack, ppu_ack, cpu_ack;
  logic [7:0]  ppu_dout, cpu_dout;
  logic [24:0] mem_addr;
  logic        mem_we, mem_oeA, mem_oeB;
  logic [7:0]  mem_din, mem_doutA, mem_doutB;

  int checks = 0;
  int errors = 0;

  logic [3:0]  m_ph = 4'd0;
  bit          hold_low = 1'b0;

  // Per-slot observations
  logic [2:0]  s_str;
  logic [24:0] s_addr;
  logic [7:0]  s_din;
  bit          s_stable;
  int          s_n_ldr, s_n_ppu, s_n_cpu, s_ack_ph;

  sdram_req_arb #(.GUARD_SLOTS(8)) dut (
    .clk(clk), .reset_n(reset_n), .clkref(clkref),
    .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_din(ldr_din), .ldr_ack(ldr_ack),
    .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_ack(ppu_ack), .ppu_dout(ppu_dout),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
    .mem_oeA(mem_oeA), .mem_oeB(mem_oeB),
    .mem_doutA(mem_doutA), .mem_doutB(mem_doutB)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock; inputs sampled at the edge advance the reference phase, then clkref is redriven.
  task automatic step();
    @(posedge clk);
    #1;
    if (!reset_n)          m_ph = 4'd0;
    else if (m_ph == 4'd15) m_ph = clkref ? 4'd0 : 4'd15;
    else if (m_ph == 4'd0)  m_ph = clkref ? 4'd0 : 4'd1;
    else                    m_ph = m_ph + 4'd1;
    clkref = !hold_low && (m_ph == 4'd15);
  endtask

  task automatic wait_slot_edge();
    for (int i = 0; i < 40 && m_ph != 4'd15; i++) step();
    if (m_ph != 4'd15) begin
      checks++; errors++;
      $display("FAIL wait_slot_edge: phase %0d required 15", m_ph);
    end
  endtask

  // Runs one full slot from ph 15 to ph 15, recording strobes, stability and acks.
  task automatic observe_slot(input bit drop);
    step();
    s_str = {mem_we, mem_oeA, mem_oeB};
    s_addr = mem_addr; s_din = mem_din;
    s_stable = 1'b1; s_n_ldr = 0; s_n_ppu = 0; s_n_cpu = 0; s_ack_ph = -1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) step();
      if ({mem_we, mem_oeA, mem_oeB} != s_str || mem_addr != s_addr || mem_din != s_din)
        s_stable = 1'b0;
      if (ldr_ack) begin s_n_ldr++; s_ack_ph = int'(m_ph); if (drop) ldr_req = 1'b0; end
      if (ppu_ack) begin s_n_ppu++; s_ack_ph = int'(m_ph); if (drop) ppu_req = 1'b0; end
      if (cpu_ack) begin s_n_cpu++; s_ack_ph = int'(m_ph); if (drop) cpu_req = 1'b0; end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clkref = 1'b0;
    ldr_req = 0; ppu_req = 0; cpu_req = 0; cpu_we = 0;
    ldr_addr = '0; ppu_addr = '0; cpu_addr = '0; ldr_din = '0; cpu_din = '0;
    mem_doutA = 8'hFF; mem_doutB = 8'hFF;
    repeat (3) step();
    checks++; if ({ldr_ack, ppu_ack, cpu_ack} !== 3'b000) begin errors++;
      $display("FAIL reset_acks: got %b required 000", {ldr_ack, ppu_ack, cpu_ack}); end
    checks++; if ({mem_we, mem_oeA, mem_oeB} !== 3'b000) begin errors++;
      $display("FAIL reset_strobes: got %b required 000", {mem_we, mem_oeA, mem_oeB}); end
    checks++; if (mem_addr !== 25'h0) begin errors++;
      $display("FAIL reset_addr: got %h required 0", mem_addr); end
    checks++; if (mem_din !== 8'h00) begin errors++;
      $display("FAIL reset_din: got %h required 00", mem_din); end
    checks++; if ({cpu_dout, ppu_dout} !== 16'h0000) begin errors++;
      $display("FAIL reset_dout: got %h required 0000", {cpu_dout, ppu_dout}); end
    reset_n = 1'b1;
  endtask

  task automatic test_cpu_read();
    bit early = 1'b0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 25'h0001234; cpu_din = 8'h77; mem_doutA = 8'hA5;
    for (int i = 0; i < 40 && m_ph != 4'd15; i++) begin
      step();
      if (mem_oeA || cpu_ack) early = 1'b1;
    end
    checks++; if (early || m_ph != 4'd15) begin errors++;
      $display("FAIL early_grant: grant seen=%0b phase=%0d required none before 15->0", early, m_ph); end
    observe_slot(1'b1);
    mem_doutA = 8'h00;
    checks++; if (s_str !== 3'b010) begin errors++;
      $display("FAIL rd_strobes: got %b required 010", s_str); end
    checks++; if (s_addr !== 25'h0001234) begin errors++;
      $display("FAIL rd_addr: got %h required 0001234", s_addr); end
    checks++; if (!s_stable) begin errors++;
      $display("FAIL rd_stable: got 0 required 1"); end
    checks++; if ({s_n_ldr, s_n_ppu, s_n_cpu} !== {32'd0, 32'd0, 32'd1}) begin errors++;
      $display("FAIL rd_acks: ldr %0d ppu %0d cpu %0d required 0 0 1", s_n_ldr, s_n_ppu, s_n_cpu); end
    checks++; if (s_ack_ph != 9) begin errors++;
      $display("FAIL rd_ack_ph: got %0d required 9", s_ack_ph); end
    checks++; if (cpu_dout !== 8'hA5) begin errors++;
      $display("FAIL rd_dout: got %h required A5", cpu_dout); end
  endtask

  task automatic test_priority();
    ldr_req = 1; ldr_addr = 25'h0100000; ldr_din = 8'h5A;
    ppu_req = 1; ppu_addr = 25'h0200040; mem_doutB = 8'hC3;
    cpu_req = 1; cpu_we = 0; cpu_addr = 25'h0000777; cpu_din = 8'h11; mem_doutA = 8'h96;
    wait_slot_edge();
    observe_slot(1'b1);
    checks++; if ({s_str, s_addr, s_din} !== {3'b100, 25'h0100000, 8'h5A}) begin errors++;
      $display("FAIL pri_slot1: strobes %b addr %h din %h required 100 0100000 5A", s_str, s_addr, s_din); end
    checks++; if ({s_n_ldr, s_n_ppu, s_n_cpu} !== {32'd1, 32'd0, 32'd0}) begin errors++;
      $display("FAIL pri_slot1_acks: %0d %0d %0d required 1 0 0", s_n_ldr, s_n_ppu, s_n_cpu); end
    checks++; if ({cpu_dout, ppu_dout} !== 16'hA500) begin errors++;
      $display("FAIL pri_slot1_dout: got %h required A500", {cpu_dout, ppu_dout}); end
    observe_slot(1'b1);
    checks++; if ({s_str, s_addr, s_din} !== {3'b001, 25'h0200040, 8'h5A}) begin errors++;
      $display("FAIL pri_slot2: strobes %b addr %h din %h required 001 0200040 5A", s_str, s_addr, s_din); end
    checks++; if ({s_n_ldr, s_n_ppu, s_n_cpu} !== {32'd0, 32'd1, 32'd0}) begin errors++;
      $display("FAIL pri_slot2_acks: %0d %0d %0d required 0 1 0", s_n_ldr, s_n_ppu, s_n_cpu); end
    checks++; if ({cpu_dout, ppu_dout} !== 16'hA5C3) begin errors++;
      $display("FAIL pri_slot2_dout: got %h required A5C3", {cpu_dout, ppu_dout}); end
    observe_slot(1'b1);
    checks++; if ({s_str, s_addr} !== {3'b010, 25'h0000777}) begin errors++;
      $display("FAIL pri_slot3: strobes %b addr %h required 010 0000777", s_str, s_addr); end
    checks++; if ({s_n_ldr, s_n_ppu, s_n_cpu} !== {32'd0, 32'd0, 32'd1}) begin errors++;
      $display("FAIL pri_slot3_acks: %0d %0d %0d required 0 0 1", s_n_ldr, s_n_ppu, s_n_cpu); end
    checks++; if ({cpu_dout, ppu_dout} !== 16'h96C3) begin errors++;
      $display("FAIL pri_slot3_dout: got %h required 96C3", {cpu_dout, ppu_dout}); end
    observe_slot(1'b1);
    checks++; if ({s_str, s_addr, s_n_ldr + s_n_ppu + s_n_cpu} !== {3'b000, 25'h0000777, 32'd0}) begin errors++;
      $display("FAIL idle_slot: strobes %b addr %h acks %0d required 000 0000777 0", s_str, s_addr, s_n_ldr + s_n_ppu + s_n_cpu); end
  endtask

  task automatic test_cpu_write();
    cpu_req = 1; cpu_we = 1; cpu_addr = 25'h0000055; cpu_din = 8'h3C; mem_doutA = 8'hEE;
    wait_slot_edge();
    observe_slot(1'b1);
    cpu_we = 0;
    checks++; if ({s_str, s_addr, s_din} !== {3'b100, 25'h0000055, 8'h3C}) begin errors++;
      $display("FAIL wr_bus: strobes %b addr %h din %h required 100 0000055 3C", s_str, s_addr, s_din); end
    checks++; if (s_n_cpu != 1 || s_ack_ph != 9) begin errors++;
      $display("FAIL wr_ack: count %0d phase %0d required 1 9", s_n_cpu, s_ack_ph); end
    checks++; if (cpu_dout !== 8'h96) begin errors++;
      $display("FAIL wr_dout_hold: got %h required 96", cpu_dout); end
  endtask

  task automatic test_refresh_guard();
    logic [9:0] oeb_seq = '0;
    logic [9:0] exp_seq;
    int n_acks = 0;
    int exp_acks;
`ifdef SDRAM_ARB_REFRESH_GUARD_EN
    exp_seq = 10'b10_1111_1111; exp_acks = 9;
`else
    exp_seq = 10'b11_1111_1111; exp_acks = 10;
`endif
    wait_slot_edge();
    observe_slot(1'b1);
    ppu_req = 1; ppu_addr = 25'h0000ABC; mem_doutB = 8'h11;
    for (int k = 0; k < 10; k++) begin
      observe_slot(1'b0);
      oeb_seq[k] = s_str[0];
      n_acks += s_n_ppu;
      if (k == 8) begin
        checks++;
`ifdef SDRAM_ARB_REFRESH_GUARD_EN
        if (s_str !== 3'b000) begin errors++;
          $display("FAIL guard_idle_strobes: got %b required 000", s_str); end
`else
        if (s_str !== 3'b001) begin errors++;
          $display("FAIL guard_off_slot9: got %b required 001", s_str); end
`endif
      end
    end
    ppu_req = 0;
    checks++; if (oeb_seq !== exp_seq) begin errors++;
      $display("FAIL guard_seq: got %b required %b", oeb_seq, exp_seq); end
    checks++; if (n_acks != exp_acks) begin errors++;
      $display("FAIL guard_acks: got %0d required %0d", n_acks, exp_acks); end
    checks++; if (ppu_dout !== 8'h11) begin errors++;
      $display("FAIL guard_dout: got %h required 11", ppu_dout); end
  endtask

  task automatic test_reset_mid_slot();
    bit bad = 1'b0;
    int n = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 25'h0000ABC; mem_doutA = 8'h42;
    wait_slot_edge();
    step();
    checks++; if (mem_oeA !== 1'b1) begin errors++;
      $display("FAIL mid_grant: oeA %b required 1", mem_oeA); end
    while (m_ph != 4'd5) step();
    reset_n = 1'b0;
    step();
    checks++; if ({ldr_ack, ppu_ack, cpu_ack, mem_we, mem_oeA, mem_oeB} !== 6'b0) begin errors++;
      $display("FAIL mid_rst_ctrl: got %b required 000000", {ldr_ack, ppu_ack, cpu_ack, mem_we, mem_oeA, mem_oeB}); end
    checks++; if ({mem_addr, mem_din, cpu_dout, ppu_dout} !== 49'h0) begin errors++;
      $display("FAIL mid_rst_data: addr %h din %h cpu %h ppu %h required all 0", mem_addr, mem_din, cpu_dout, ppu_dout); end
    for (int i = 0; i < 10; i++) begin
      step();
      if (cpu_ack) bad = 1'b1;
    end
    reset_n = 1'b1;
    while (m_ph != 4'd15 && n < 40) begin
      step(); n++;
      if (mem_oeA || cpu_ack) bad = 1'b1;
    end
    checks++; if (bad || n != 15) begin errors++;
      $display("FAIL post_rst_idle: grant seen=%0b steps %0d required 0 15", bad, n); end
    observe_slot(1'b1);
    checks++; if ({s_str, s_n_cpu, cpu_dout} !== {3'b010, 32'd1, 8'h42}) begin errors++;
      $display("FAIL post_rst_grant: strobes %b acks %0d dout %h required 010 1 42", s_str, s_n_cpu, cpu_dout); end
  endtask

  task automatic test_clkref_stall();
    bit bad = 1'b0;
    wait_slot_edge();
    observe_slot(1'b1);
    hold_low = 1'b1; clkref = 1'b0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 25'h0000321; mem_doutA = 8'h5E;
    for (int i = 0; i < 40; i++) begin
      step();
      if (mem_oeA || cpu_ack) bad = 1'b1;
    end
    checks++; if (bad) begin errors++;
      $display("FAIL stall_no_slot: grant or ack seen=1 required 0"); end
    hold_low = 1'b0; clkref = (m_ph == 4'd15);
    observe_slot(1'b1);
    checks++; if ({s_str, s_addr, s_n_cpu, s_ack_ph} !== {3'b010, 25'h0000321, 32'd1, 32'd9}) begin errors++;
      $display("FAIL stall_resume: strobes %b addr %h acks %0d ph %0d required 010 0000321 1 9", s_str, s_addr, s_n_cpu, s_ack_ph); end
    checks++; if (cpu_dout !== 8'h5E) begin errors++;
      $display("FAIL stall_dout: got %h required 5E", cpu_dout); end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_priority();
    test_cpu_write();
    test_refresh_guard();
    test_reset_mid_slot();
    test_clkref_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_req_arb.md
SDRAM_REQ_ARB -- requirements
Module: sdram_req_arb

Interface
REQ-001 SHALL have port clk  in  1  SDRAM clock (85 MHz), sole clock.
REQ-002 SHALL have port reset_n  in  1  synchronous, active-low reset.
REQ-003 SHALL have port clkref  in  1  system reference clock (21.477 MHz), sampled in clk domain.
REQ-004 SHALL have ports ldr_req in 1, ldr_addr in 25, ldr_din in 8, ldr_ack out 1  ROM loader write requester.
REQ-005 SHALL have ports ppu_req in 1, ppu_addr in 25, ppu_ack out 1, ppu_dout out 8  PPU read requester.
REQ-006 SHALL have ports cpu_req in 1, cpu_we in 1, cpu_addr in 25, cpu_din in 8, cpu_ack out 1, cpu_dout out 8  CPU read/write requester.
REQ-007 SHALL have ports mem_addr out 25, mem_we out 1, mem_din out 8, mem_oeA out 1, mem_oeB out 1  request bus to SDRAM controller.
REQ-008 SHALL have ports mem_doutA in 8, mem_doutB in 8  read data from SDRAM controller (CPU / PPU).
REQ-009 SHALL have parameter GUARD_SLOTS, default 8, max consecutive busy slots before a forced idle (refresh) slot.

Function
REQ-010 SHALL keep 4-bit phase counter ph: advance 15->0 only when clkref=1, 0->1 only when clkref=0, all other states unconditionally (ph+1, wrap 15->0).
REQ-011 SHALL make grant decisions only on the clk edge where ph moves 15->0 ("slot start").
REQ-012 SHALL grant by fixed priority ldr > ppu > cpu among requesters with req=1 at slot start.
REQ-013 SHALL, on grant, register mem_addr/mem_din from the granted port and hold them, mem_we, mem_oeA, mem_oeB constant for ph 0..15 of that slot.
REQ-014 SHALL drive: ldr -> mem_we=1; ppu -> mem_oeB=1; cpu read -> mem_oeA=1; cpu write (cpu_we=1) -> mem_we=1; oe outputs 0 on writes.
REQ-015 SHALL, with no grant, drive mem_we=mem_oeA=mem_oeB=0 for the whole slot (controller refreshes); mem_addr/mem_din hold last value.
REQ-016 SHALL, on edge where ph moves 8->9 in a granted slot, assert granted port's ack for exactly one clk; for reads load cpu_dout<=mem_doutA or ppu_dout<=mem_doutB on that same edge.
REQ-017 SHALL hold cpu_dout/ppu_dout until next read ack of the same port; writes leave them unchanged.
REQ-018 SHALL require requester to hold req, addr, din, we stable until ack; req still high after ack = new request at next slot start.
REQ-019 SHALL ignore req changes inside a slot; req dropped before slot start is never granted, never acked.
REQ-020 SHALL count consecutive granted slots in busy_cnt (saturating at GUARD_SLOTS); idle slot clears it.
REQ-021 SHALL, at most one slot granted per slot; simultaneous requests: losers wait, no ack, no data change.

Reset
REQ-022 SHALL, with reset_n=0 at a clk edge: ph=0, busy_cnt=0, all acks 0, mem_we/mem_oeA/mem_oeB=0, mem_addr=0, mem_din=0, cpu_dout=ppu_dout=8'h00.
REQ-023 SHALL abandon an in-flight slot on reset: no ack issued for it, outputs 0 from next clk.
REQ-024 SHALL issue no grant before the first 15->0 transition after reset_n rises (resynchronises with controller).

Configuration
REQ-025 SHALL compile refresh guard only when SDRAM_ARB_REFRESH_GUARD_EN is defined: if busy_cnt=GUARD_SLOTS at slot start, force idle slot regardless of requests, requests stay pending.
REQ-026 SHALL, without SDRAM_ARB_REFRESH_GUARD_EN, grant every slot with a pending request; busy_cnt logic absent.

Verification
REQ-027 SHALL cover: cpu_req=1, cpu_we=0, cpu_addr=25'h0001234, mem_doutA=8'hA5 -> mem_oeA=1 whole slot, mem_addr=25'h0001234, cpu_ack one clk at ph 9, cpu_dout=8'hA5.
REQ-028 SHALL cover: ldr_req, ppu_req, cpu_req all 1 at same slot start -> slot1 ldr (mem_we=1), slot2 ppu (mem_oeB=1), slot3 cpu; exactly one ack per slot.
REQ-029 SHALL cover: cpu_we=1, cpu_din=8'h3C -> mem_we=1, mem_din=8'h3C, mem_oeA=0, cpu_ack at ph 9, cpu_dout unchanged.
REQ-030 SHALL cover: SDRAM_ARB_REFRESH_GUARD_EN defined, GUARD_SLOTS=8, ppu_req held 1 -> 8 granted slots, 1 idle slot (all strobes 0), then grants resume; undefined -> no idle slot.
REQ-031 SHALL cover: reset_n=0 at ph 5 of granted cpu read -> no cpu_ack, outputs 0 next clk; after release, first grant only after first 15->0 transition.
REQ-032 SHALL cover: clkref held 0 -> ph stalls at 15, no new slot, no ack; clkref toggling resumes slots.
